// File: rtl/debounce_sync_pkg.sv
// Shared types and constants for the debounce_sync input conditioner.
// The state encoding is fixed so that q and busy decode directly from
// the state register: bit 1 is the accepted level, bit 1 ^ bit 0 marks
// a qualification in progress.
package debounce_sync_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'b00,
        ST_CHK_HIGH = 2'b01,
        ST_HIGH     = 2'b11,
        ST_CHK_LOW  = 2'b10
    } state_e;

    localparam int MIN_SYNC_STAGES   = 2;
    localparam int MIN_STABLE_CYCLES = 1;

    // True when the parameter pair is within the supported range.
    function automatic bit params_legal(input int sync_stages, input int stable_cycles);
        return (sync_stages >= MIN_SYNC_STAGES) && (stable_cycles >= MIN_STABLE_CYCLES);
    endfunction

endpackage

// File: rtl/debounce_sync_sync_nff.sv
// Generic N-stage flop synchronizer for a single asynchronous bit.
// Pure shift chain: nothing sits between the stages so each flop gets a
// full cycle to resolve metastability.
module sync_nff
    import debounce_sync_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages_q;
    logic [N-1:0] stages_d;

    if (N < MIN_SYNC_STAGES) begin : g_bad_depth
        $error("sync_nff: N must be at least %0d", MIN_SYNC_STAGES);
    end

    // Shift the raw input one stage deeper each cycle.
    always_comb begin
        stages_d = {stages_q[N-2:0], d};
    end

    // Synchronizer flops, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages_q <= '0;
        end else begin
            stages_q <= stages_d;
        end
    end

    assign q = stages_q[N-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronizes din, then accepts a new level only after it has
// been seen on STABLE_CYCLES consecutive enabled samples. Produces the
// debounced level plus registered one-cycle rise/fall pulses.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic en,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (!params_legal(SYNC_STAGES, STABLE_CYCLES)) begin : g_bad_params
        $error("debounce_sync: SYNC_STAGES >= %0d and STABLE_CYCLES >= %0d required",
               MIN_SYNC_STAGES, MIN_STABLE_CYCLES);
    end

    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    sync_nff #(
        .N (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (s)
    );

    // Next-state, sample counter and pulse logic for the stability filter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_LOW: begin
                if (s && en) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_HIGH;
                    end else begin
                        state_d = ST_CHK_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_CHK_HIGH: begin
                if (!s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_HIGH: begin
                if (!s && en) begin
                    if (STABLE_CYCLES == 1) begin
                        state_d = ST_LOW;
                    end else begin
                        state_d = ST_CHK_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            ST_CHK_LOW: begin
                if (s) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (en) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
        rise_d = (state_d == ST_HIGH) && ((state_q == ST_LOW) || (state_q == ST_CHK_HIGH));
        fall_d = (state_d == ST_LOW)  && ((state_q == ST_HIGH) || (state_q == ST_CHK_LOW));
    end

    // State, counter and pulse registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign q    = (state_q == ST_HIGH) || (state_q == ST_CHK_LOW);
    assign busy = (state_q == ST_CHK_HIGH) || (state_q == ST_CHK_LOW);
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Testbench for debounce_sync: a default-parameter instance driven from a
// vector table, plus a SYNC_STAGES=3 / STABLE_CYCLES=1 instance checked
// against a delayed-copy model of din.
module tb_debounce_sync;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic en;
    logic q1, rise1, fall1, busy1;
    logic q2, rise2, fall2, busy2;

    typedef struct packed {
        logic rst;
        logic din;
        logic en;
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    typedef struct packed {
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   dutSel      = 1;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    debounce_sync dut1 (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .q    (q1),
        .rise (rise1),
        .fall (fall1),
        .busy (busy1)
    );

    debounce_sync #(
        .SYNC_STAGES   (3),
        .STABLE_CYCLES (1)
    ) dut2 (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .en   (en),
        .q    (q2),
        .rise (rise2),
        .fall (fall2),
        .busy (busy2)
    );

    task automatic addVec(input logic r, input logic d, input logic e,
                          input logic eq, input logic er, input logic ef, input logic eb);
        vec_t v;
        v.rst = r; v.din = d; v.en = e;
        v.q = eq; v.rise = er; v.fall = ef; v.busy = eb;
        vecs.push_back(v);
    endtask

    task automatic compareBit(input string name, input logic act, input logic exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, queue what must appear after the next edge.
    task automatic applyStimulus(input logic r, input logic d, input logic e, input exp_t ex);
        rst = r;
        din = d;
        en  = e;
        sb.push_back(ex);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        exp_t ex;
        logic aq, ar, af, ab;
        if (sb.size() == 0) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s: scoreboard empty, got nothing, expected an entry", tag);
            return;
        end
        ex = sb.pop_front();
        if (dutSel == 1) begin
            aq = q1; ar = rise1; af = fall1; ab = busy1;
        end else begin
            aq = q2; ar = rise2; af = fall2; ab = busy2;
        end
        compareBit({tag, ".q"},    aq, ex.q);
        compareBit({tag, ".rise"}, ar, ex.rise);
        compareBit({tag, ".fall"}, af, ex.fall);
        compareBit({tag, ".busy"}, ab, ex.busy);
    endtask

    task automatic runVectors(input string phase);
        exp_t ex;
        foreach (vecs[i]) begin
            ex.q = vecs[i].q; ex.rise = vecs[i].rise; ex.fall = vecs[i].fall; ex.busy = vecs[i].busy;
            applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].en, ex);
            checkOutput($sformatf("%s[%0d]", phase, i));
        end
        vecs.delete();
    endtask

    initial begin
        logic pat[12];
        logic prevQ;
        logic expQ;
        exp_t ex;

        rst = 1'b1;
        din = 1'b0;
        en  = 1'b1;

        // Reset held with din high: everything stays low.
        for (int i = 0; i < 10; i++) addVec(1, 1, 1, 0, 0, 0, 0);
        // Release with din steady high: busy for 3 cycles, rise after edge 5.
        addVec(0, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 1, 1, 1, 1, 0, 0);
        addVec(0, 1, 1, 1, 0, 0, 0);
        addVec(0, 1, 1, 1, 0, 0, 0);
        runVectors("reset_rise");

        // Falling edge: q held during CHK_LOW, single fall pulse after edge 5.
        addVec(0, 0, 1, 1, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 1);
        addVec(0, 0, 1, 1, 0, 0, 1);
        addVec(0, 0, 1, 1, 0, 0, 1);
        addVec(0, 0, 1, 0, 0, 1, 0);
        addVec(0, 0, 1, 0, 0, 0, 0);
        runVectors("fall");

        // Qualification abandoned while en is low: s==0 still returns to LOW.
        addVec(0, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 0);
        runVectors("abandon_en0");

        // Glitch of 3 cycles: one sample short, no pulse, q stays low.
        addVec(0, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 0, 1, 0, 0, 0, 1);
        addVec(0, 0, 1, 0, 0, 0, 1);
        addVec(0, 0, 1, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 0);
        runVectors("glitch");

        // en every other cycle: rise on the 4th enabled sample of s==1.
        addVec(0, 1, 1, 0, 0, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 0);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 1, 0, 0, 0, 0, 1);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 1, 0, 0, 0, 0, 1);
        addVec(0, 1, 1, 0, 0, 0, 1);
        addVec(0, 1, 0, 0, 0, 0, 1);
        addVec(0, 1, 1, 1, 1, 0, 0);
        addVec(0, 1, 0, 1, 0, 0, 0);
        runVectors("en_gate");

        // Start a falling qualification, then reset between clock edges.
        addVec(0, 0, 1, 1, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 1);
        runVectors("pre_async");
        #3;
        rst = 1'b1;
        #1;
        compareBit("async_rst.q",    q1,    1'b0);
        compareBit("async_rst.rise", rise1, 1'b0);
        compareBit("async_rst.fall", fall1, 1'b0);
        compareBit("async_rst.busy", busy1, 1'b0);
        addVec(1, 0, 1, 0, 0, 0, 0);
        addVec(1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) addVec(0, 0, 1, 0, 0, 0, 0);
        runVectors("post_async");

        // STABLE_CYCLES=1, SYNC_STAGES=3: q is din delayed by 3 edges.
        dutSel = 2;
        pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        prevQ  = 1'b0;
        for (int k = 0; k < 12; k++) begin
            expQ    = (k >= 3) ? pat[k-3] : 1'b0;
            ex.q    = expQ;
            ex.rise = expQ & ~prevQ;
            ex.fall = ~expQ & prevQ;
            ex.busy = 1'b0;
            prevQ   = expQ;
            applyStimulus(1'b0, pat[k], 1'b1, ex);
            checkOutput($sformatf("fast[%0d]", k));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
